csl_request_queue: RTL and testbench



---
 rtl/csl_pkg.sv | 29 ++
 rtl/csl_req_fifo.sv | 71 +++++++
 rtl/csl_request_queue.sv | 142 ++++++++++++++
 tb/tb_csl_request_queue.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/csl_pkg.sv
// Shared constants for the CSL request queue: ASCII framing bytes, parser
// states and the destination unit table (letter plus start/end/prev nodes).
package csl_pkg;

  localparam logic [7:0] CH_C    = 8'h43;
  localparam logic [7:0] CH_S    = 8'h53;
  localparam logic [7:0] CH_L    = 8'h4C;
  localparam logic [7:0] CH_DASH = 8'h2D;
  localparam logic [7:0] CH_U    = 8'h55;
  localparam logic [7:0] CH_HASH = 8'h23;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT_C,
    ST_GOT_S,
    ST_GOT_L,
    ST_GOT_D1,
    ST_GOT_UNIT,
    ST_GOT_U,
    ST_GOT_D2
  } parse_state_t;

  // Table order is PU, FU, WU, spare; NUM_UNITS selects a prefix of it.
  localparam logic [7:0] UNIT_LETTER [4] = '{8'h50, 8'h46, 8'h57, 8'h58};
  localparam logic [7:0] UNIT_START  [4] = '{8'd10, 8'd24, 8'd18, 8'd0};
  localparam logic [7:0] UNIT_END    [4] = '{8'd30, 8'd19, 8'd11, 8'd0};
  localparam logic [7:0] UNIT_PREV   [4] = '{8'd28, 8'd18, 8'd12, 8'd0};

endpackage

// File: rtl/csl_req_fifo.sv
// Synchronous FIFO of 1-based unit indices. Occupancy is tracked in an
// explicit counter so full/empty never depend on pointer equality. Also
// reports whether a given value is present in any occupied slot.
module csl_req_fifo
  import csl_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] match_data,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              match_any
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  slot_off;
  logic              pop_ok;
  logic              push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot a push into a full queue needs.
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rd_ptr];

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents of unoccupied slots are don't-care.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // OR of per-slot compares, restricted to slots holding live entries.
  always_comb begin
    match_any = 1'b0;
    slot_off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = PTR_W'(i) - rd_ptr;
      if ((CNT_W'(slot_off) < count) && (mem[i] == match_data)) match_any = 1'b1;
    end
  end

endmodule

// File: rtl/csl_request_queue.sv
// CSL request queue: parses "CSL-<L>U-#" byte streams from the UART and
// queues decoded unit requests; the queue head drives the path controller.
// Build option: define CSL_DEDUP_EN to silently drop requests whose unit is
// already pending (head included).
module csl_request_queue
  import csl_pkg::*;
#(
  parameter int NODE_W      = 5,
  parameter int QUEUE_DEPTH = 4,
  parameter int NUM_UNITS   = 3,
  localparam int UIDX_W     = $clog2(NUM_UNITS + 1),
  localparam int CNT_W      = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_complete,
  input  logic [7:0]           rx_msg,
  input  logic                 task_complete,
  output logic                 req_valid,
  output logic [NUM_UNITS-1:0] go_unit,
  output logic [UIDX_W-1:0]    unit_type,
  output logic [NODE_W-1:0]    csl_start,
  output logic [NODE_W-1:0]    csl_end,
  output logic [NODE_W-1:0]    csl_prev_node_of_end_point,
  output logic [CNT_W-1:0]     queue_count,
  output logic                 overflow
);

`ifdef CSL_DEDUP_EN
  localparam logic DEDUP_EN = 1'b1;
`else
  localparam logic DEDUP_EN = 1'b0;
`endif

  parse_state_t      state_q, state_d;
  logic [UIDX_W-1:0] unit_q, unit_d;
  logic [UIDX_W-1:0] letter_idx;
  logic [UIDX_W-1:0] head_idx;
  logic              letter_hit;
  logic              msg_done;
  logic              push_req;
  logic              dup;
  logic              q_full;
  logic              q_empty;

  // Parser state register; the latched unit index is payload, not control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Latch the decoded unit index while the rest of the frame arrives.
  always_ff @(posedge clk) begin
    unit_q <= unit_d;
  end

  // Parser next state: any mismatch restarts at GOT_C on 'C' so "CCSL-" resyncs.
  always_comb begin
    state_d    = state_q;
    unit_d     = unit_q;
    msg_done   = 1'b0;
    letter_hit = 1'b0;
    letter_idx = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (rx_msg == UNIT_LETTER[i]) begin
        letter_hit = 1'b1;
        letter_idx = UIDX_W'(i + 1);
      end
    end
    if (rx_complete) begin
      state_d = (rx_msg == CH_C) ? ST_GOT_C : ST_IDLE;
      case (state_q)
        ST_GOT_C:    if (rx_msg == CH_S)    state_d = ST_GOT_S;
        ST_GOT_S:    if (rx_msg == CH_L)    state_d = ST_GOT_L;
        ST_GOT_L:    if (rx_msg == CH_DASH) state_d = ST_GOT_D1;
        ST_GOT_D1: begin
          if (letter_hit) begin
            state_d = ST_GOT_UNIT;
            unit_d  = letter_idx;
          end
        end
        ST_GOT_UNIT: if (rx_msg == CH_U)    state_d = ST_GOT_U;
        ST_GOT_U:    if (rx_msg == CH_DASH) state_d = ST_GOT_D2;
        ST_GOT_D2: begin
          if (rx_msg == CH_HASH) begin
            state_d  = ST_IDLE;
            msg_done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign push_req = msg_done & ~(DEDUP_EN & dup);

  csl_req_fifo #(
    .DEPTH  (QUEUE_DEPTH),
    .DATA_W (UIDX_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_req),
    .pop        (task_complete),
    .wdata      (unit_q),
    .match_data (unit_q),
    .rdata      (head_idx),
    .count      (queue_count),
    .full       (q_full),
    .empty      (q_empty),
    .match_any  (dup)
  );

  // Sticky drop flag: push into a full queue with no simultaneous pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else if (push_req && q_full && !(task_complete && !q_empty)) overflow <= 1'b1;
  end

  assign req_valid = ~q_empty;

  // Head decode: one-hot go and table node lookup, all zero when empty.
  always_comb begin
    go_unit                    = '0;
    unit_type                  = '0;
    csl_start                  = '0;
    csl_end                    = '0;
    csl_prev_node_of_end_point = '0;
    if (req_valid) begin
      unit_type = head_idx;
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (head_idx == UIDX_W'(i + 1)) begin
          go_unit[i]                 = 1'b1;
          csl_start                  = NODE_W'(UNIT_START[i]);
          csl_end                    = NODE_W'(UNIT_END[i]);
          csl_prev_node_of_end_point = NODE_W'(UNIT_PREV[i]);
        end
      end
    end
  end

endmodule

// File: tb/tb_csl_request_queue.sv
// Self-checking bench for csl_request_queue: directed scenarios followed by
// random byte streams, compared against a frame-window reference model.
module tb_csl_request_queue;

  localparam int NODE_W = 5;
  localparam int DEPTH  = 4;
  localparam int NU     = 3;
  localparam int UW     = $clog2(NU + 1);
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst_n;
  logic              rx_complete;
  logic [7:0]        rx_msg;
  logic              task_complete;
  logic              req_valid;
  logic [NU-1:0]     go_unit;
  logic [UW-1:0]     unit_type;
  logic [NODE_W-1:0] csl_start;
  logic [NODE_W-1:0] csl_end;
  logic [NODE_W-1:0] csl_prev;
  logic [CW-1:0]     queue_count;
  logic              overflow;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] win [8];
  int         mq[$];
  bit         m_ovf;

  int         ST_T [4] = '{10, 24, 18, 0};
  int         EN_T [4] = '{30, 19, 11, 0};
  int         PV_T [4] = '{28, 18, 12, 0};
  logic [7:0] LET  [4] = '{"P", "F", "W", "X"};
  logic [7:0] ALPH [12] = '{"C", "S", "L", "-", "P", "F", "W", "U", "#", "X", "Q", "C"};

  csl_request_queue #(
    .NODE_W      (NODE_W),
    .QUEUE_DEPTH (DEPTH),
    .NUM_UNITS   (NU)
  ) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .rx_complete                (rx_complete),
    .rx_msg                     (rx_msg),
    .task_complete              (task_complete),
    .req_valid                  (req_valid),
    .go_unit                    (go_unit),
    .unit_type                  (unit_type),
    .csl_start                  (csl_start),
    .csl_end                    (csl_end),
    .csl_prev_node_of_end_point (csl_prev),
    .queue_count                (queue_count),
    .overflow                   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) win[i] = 8'h00;
    mq.delete();
    m_ovf = 1'b0;
  endtask

  // A frame is decoded when the last eight bytes read "CSL-<L>U-#".
  task automatic model_step(input bit v, input logic [7:0] b, input bit tc);
    bit msg;
    bit dupl;
    int nu;
    msg  = 1'b0;
    dupl = 1'b0;
    nu   = 0;
    if (v) begin
      for (int i = 0; i < 7; i++) win[i] = win[i + 1];
      win[7] = b;
      if (win[0] == "C" && win[1] == "S" && win[2] == "L" && win[3] == "-" &&
          win[5] == "U" && win[6] == "-" && win[7] == "#")
        for (int k = 0; k < NU; k++)
          if (win[4] == LET[k]) begin
            msg = 1'b1;
            nu  = k + 1;
          end
    end
`ifdef CSL_DEDUP_EN
    foreach (mq[i]) if (msg && mq[i] == nu) dupl = 1'b1;
`endif
    if (tc && mq.size() > 0) void'(mq.pop_front());
    if (msg && !dupl) begin
      if (mq.size() < DEPTH) mq.push_back(nu);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    int u;
    u = (mq.size() > 0) ? mq[0] : 0;
    chk({tag, ":req_valid"}, req_valid, (u != 0));
    chk({tag, ":unit_type"}, unit_type, u);
    chk({tag, ":go_unit"}, go_unit, (u != 0) ? (1 << (u - 1)) : 0);
    chk({tag, ":start"}, csl_start, (u != 0) ? ST_T[u - 1] : 0);
    chk({tag, ":end"}, csl_end, (u != 0) ? EN_T[u - 1] : 0);
    chk({tag, ":prev"}, csl_prev, (u != 0) ? PV_T[u - 1] : 0);
    chk({tag, ":count"}, queue_count, mq.size());
    chk({tag, ":overflow"}, overflow, m_ovf);
  endtask

  task automatic step(input string tag, input bit v, input logic [7:0] b, input bit tc);
    rx_complete   = v;
    rx_msg        = b;
    task_complete = tc;
    @(posedge clk);
    #1;
    rx_complete   = 1'b0;
    task_complete = 1'b0;
    model_step(v, b, tc);
    check_all(tag);
  endtask

  task automatic send_msg(input string tag, input string s);
    for (int i = 0; i < s.len(); i++) step(tag, 1'b1, s[i], 1'b0);
  endtask

  task automatic do_reset(input string tag);
    rst_n         = 1'b0;
    rx_complete   = 1'b0;
    task_complete = 1'b0;
    rx_msg        = 8'h00;
    model_clear();
    #1;
    check_all({tag, ":async"});
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all(tag);
  endtask

  initial begin
    rst_n         = 1'b0;
    rx_complete   = 1'b0;
    task_complete = 1'b0;
    rx_msg        = 8'h00;
    model_clear();

    // Reset state
    do_reset("reset");

    // Single PU request, latency one after '#'
    send_msg("t1", "CSL-PU-#");
    chk("t1_type", unit_type, 1);
    chk("t1_go", go_unit, 3'b001);
    chk("t1_start", csl_start, 10);
    chk("t1_end", csl_end, 30);
    chk("t1_prev", csl_prev, 28);
    chk("t1_count", queue_count, 1);

    // FU then WU, pop in order
    do_reset("t2rst");
    send_msg("t2", "CSL-FU-#");
    send_msg("t2", "CSL-WU-#");
    chk("t2_count2", queue_count, 2);
    chk("t2_head_fu", csl_start, 24);
    step("t2pop", 1'b0, 8'h00, 1'b1);
    chk("t2_count1", queue_count, 1);
    chk("t2_head_wu", csl_end, 11);
    step("t2pop", 1'b0, 8'h00, 1'b1);
    step("t2under", 1'b0, 8'h00, 1'b1);
    chk("t2_underflow", queue_count, 0);

    // Five pushes into a depth-4 queue
    do_reset("t3rst");
    send_msg("t3", "CSL-PU-#");
    send_msg("t3", "CSL-FU-#");
    send_msg("t3", "CSL-WU-#");
    send_msg("t3", "CSL-FU-#");
    send_msg("t3", "CSL-WU-#");
`ifndef CSL_DEDUP_EN
    chk("t3_count", queue_count, 4);
    chk("t3_ovf", overflow, 1);
    chk("t3_head", unit_type, 1);
`endif

    // Full queue, push and pop on the same edge
    do_reset("t4rst");
    send_msg("t4", "CSL-PU-#");
    send_msg("t4", "CSL-FU-#");
    send_msg("t4", "CSL-WU-#");
    send_msg("t4", "CSL-PU-#");
    send_msg("t4", "CSL-FU-");
    step("t4pp", 1'b1, "#", 1'b1);
`ifndef CSL_DEDUP_EN
    chk("t4_count", queue_count, 4);
    chk("t4_ovf", overflow, 0);
`endif
    for (int i = 0; i < 4; i++) step("t4drain", 1'b0, 8'h00, 1'b1);

    // Push and pop together at count 1: new entry becomes head
    do_reset("t4brst");
    send_msg("t4b", "CSL-PU-");
    step("t4b", 1'b1, "#", 1'b0);
    send_msg("t4b", "CSL-WU-");
    step("t4bpp", 1'b1, "#", 1'b1);
    chk("t4b_head", unit_type, 3);
    chk("t4b_count", queue_count, 1);

    // Resync on doubled C and rejection of an unknown letter
    do_reset("t5rst");
    send_msg("t5", "CCSL-WU-#");
    send_msg("t5", "CSL-QU-#");
    chk("t5_count", queue_count, 1);
    chk("t5_type", unit_type, 3);

    // Duplicate requests
    do_reset("t6rst");
    send_msg("t6", "CSL-PU-#");
    send_msg("t6", "CSL-PU-#");
`ifdef CSL_DEDUP_EN
    chk("t6_count", queue_count, 1);
`else
    chk("t6_count", queue_count, 2);
`endif
    chk("t6_ovf", overflow, 0);

    // Reset in the middle of a frame
    send_msg("t7", "CSL-F");
    rst_n = 1'b0;
    model_clear();
    #1;
    check_all("t7_async");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_msg("t7", "U-#");
    chk("t7_nopush", queue_count, 0);
    send_msg("t7", "CSL-WU-#");
    chk("t7_type", unit_type, 3);

    // Random streams: whole frames mixed with noise bytes and pops
    do_reset("rnd_rst");
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) begin
        logic [7:0] fr [8];
        fr = '{"C", "S", "L", "-", "P", "U", "-", "#"};
        fr[4] = ($urandom_range(0, 4) == 4) ? 8'h51 : LET[$urandom_range(0, 3)];
        for (int i = 0; i < 8; i++) step("rnd_msg", 1'b1, fr[i], ($urandom_range(0, 5) == 0));
      end else if (r < 8) begin
        step("rnd_byte", 1'b1, ALPH[$urandom_range(0, 11)], ($urandom_range(0, 3) == 0));
      end else begin
        step("rnd_idle", 1'b0, 8'h00, ($urandom_range(0, 1) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
